debug_port_tx: RTL and testbench
================================

Name: debug_port_tx

Overview:
- Consumer end of the CPU debug port.
- Snapshots the parallel debug vector on request and serializes it as one framed UART 8N1 byte stream toward the host debug tool.
- Sits at board top level beside the cpu instance and drives the FPGA TX pin.
- Frame layout: byte 0 is the sync byte 0xA5 (vector byte 0 is reserved), followed by vector bytes 1..DEBUG_BYTES-1.

Parameters:
DEBUG_BYTES, 30, total frame bytes including sync byte 0; vector carries bytes 1..DEBUG_BYTES-1.
CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); minimum 2.
SYNC_BYTE, 8'hA5, value sent as frame byte 0.

Ports:
clk  input  1  clock, all state updates on posedge.
nreset  input  1  reset, synchronous, active-high.
debug_port_vector  input  (DEBUG_BYTES-1)*8, indexed [8:DEBUG_BYTES*8-1]  debug vector; byte k = bits [k*8 : k*8+7], bit k*8 is that byte's MSB.
trigger  input  1  request one frame; level-sampled each cycle.
uart_tx  output  1  serial line, idle high.
busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse after the last stop bit of a frame.

Behaviour:
- Reset: on any posedge with nreset=1, return to IDLE, uart_tx=1, busy=0, frame_done=0, bit counter=0, byte index=0. Applies mid-frame: the line goes high on the next edge and the partial frame is abandoned. No recovery byte is sent.
- States: IDLE, START, DATA, STOP.
- IDLE: uart_tx=1, busy=0.
  - On a posedge with trigger=1, copy debug_port_vector into a snapshot register, set byte index=0, go to START, set busy=1.
  - First start bit appears on uart_tx in the cycle after the trigger edge (1-cycle latency).
  - The live vector is never read again during the frame.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Byte 0 = SYNC_BYTE; byte k = snapshot byte k.
  - After bit 7, go to STOP.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles.
  - If the byte index is below the last byte, increment it and go to START. Bytes are back-to-back with no idle gap.
  - Otherwise go to IDLE, pulse frame_done=1 for exactly one cycle (coincident with busy falling to 0).
- Baud counter: counts 0..CLKS_PER_BIT-1 and is reset on every state or bit change.
  - Width is clog2(CLKS_PER_BIT).
  - Byte index width is clog2(DEBUG_BYTES+1).
- Frame length: DEBUG_BYTES*10*CLKS_PER_BIT cycles from the first start-bit cycle to the frame_done cycle inclusive of the final stop bit.
- Trigger while busy=1 is ignored; it is not queued.
- Trigger held high continuously: a new frame starts on the edge where frame_done is observed, with a fresh snapshot. Back-to-back frames have zero idle bits between them.
- frame_done and trigger in the same cycle: the new frame is accepted; busy stays 0 for that one cycle only.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
DEBUG_TX_CHECKSUM_EN
- Defined: after the last vector byte, one extra byte is sent before frame_done.
  - Value = XOR of snapshot bytes 1..DEBUG_BYTES-1 (sync byte excluded).
  - Frame length becomes (DEBUG_BYTES+1)*10*CLKS_PER_BIT.
  - Checksum is accumulated as bytes are loaded, or computed from the snapshot; either is acceptable as long as the value is correct.
- Undefined: no checksum byte, no XOR logic. Frame exactly as above.

Test Plan:
- Reset idle, CLKS_PER_BIT=4, DEBUG_BYTES=3: hold nreset=1 for 3 cycles -> uart_tx=1, busy=0, frame_done=0 throughout; stay idle 20 cycles after nreset=0 with trigger=0.
- Single frame, CLKS_PER_BIT=4, DEBUG_BYTES=3, vector bytes 0x12,0x34: pulse trigger one cycle.
  - Decoded bytes must be A5,12,34.
  - Each bit lasts exactly 4 cycles.
  - busy=1 for 120 cycles; frame_done pulses once in cycle 120.
  - With DEBUG_TX_CHECKSUM_EN: 4th byte 0x26, 160 cycles.
- Snapshot isolation: change vector to 0xFF,0xFF two cycles after trigger -> decoded frame is still A5,12,34.
- Busy retrigger: assert trigger again at cycle 50 of a frame -> ignored; exactly one frame_done; no second frame.
- Continuous trigger: hold trigger=1 for 2 frames -> second start bit begins the cycle after frame_done, with no idle bit between frames.
- Mid-frame reset: nreset=1 at cycle 30 of a frame -> uart_tx=1 and busy=0 on the next edge. A trigger after release yields a complete, correct frame starting with A5.

Source files
------------

// File: rtl/debug_port_tx.sv
// Debug-port consumer: snapshots the debug vector on trigger and sends it as a framed UART 8N1 stream.
// Optional trailing XOR checksum byte when DEBUG_TX_CHECKSUM_EN is defined.
module debug_port_tx #(
    parameter int unsigned DEBUG_BYTES  = 30,
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [8:DEBUG_BYTES*8-1]   debug_port_vector,
    input  logic                       trigger,
    output logic                       uart_tx,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = $clog2(DEBUG_BYTES + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(CLKS_PER_BIT - 2);
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam logic [IW-1:0] LAST_BYTE  = IW'(DEBUG_BYTES);
`else
    localparam logic [IW-1:0] LAST_BYTE  = IW'(DEBUG_BYTES - 1);
`endif

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [IW-1:0] byte_idx;
    logic [7:0]    snap [1:DEBUG_BYTES-1];
    logic [7:0]    cur_byte;

`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] vec_xor;

    always_comb begin
        vec_xor = 8'h00;
        for (int unsigned k = 1; k < DEBUG_BYTES; k++) begin
            vec_xor = vec_xor ^ debug_port_vector[k*8 +: 8];
        end
    end
`endif

    // Snapshot is taken only on the accepting edge; the live vector is ignored mid-frame.
    always_ff @(posedge clk) begin
        if (!nreset && state == StIdle && trigger) begin
            for (int unsigned k = 1; k < DEBUG_BYTES; k++) begin
                snap[k] <= debug_port_vector[k*8 +: 8];
            end
`ifdef DEBUG_TX_CHECKSUM_EN
            csum <= vec_xor;
`endif
        end
    end

    always_comb begin
        cur_byte = SYNC_BYTE;
        for (int unsigned k = 1; k < DEBUG_BYTES; k++) begin
            if (byte_idx == IW'(k)) begin
                cur_byte = snap[k];
            end
        end
`ifdef DEBUG_TX_CHECKSUM_EN
        if (byte_idx == IW'(DEBUG_BYTES)) begin
            cur_byte = csum;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state      <= StIdle;
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (trigger) begin
                        state    <= StStart;
                        busy     <= 1'b1;
                        uart_tx  <= 1'b0;
                        baud_cnt <= '0;
                        byte_idx <= '0;
                    end
                end
                StStart: begin
                    if (baud_cnt == CNT_LAST) begin
                        state    <= StData;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_tx  <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= StStop;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StStop: begin
                    // Leave one cycle early so the idle cycle doubles as the final stop-bit cycle
                    // and a held trigger restarts with no idle gap.
                    if (byte_idx == LAST_BYTE && baud_cnt == CNT_PENULT) begin
                        state      <= StIdle;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        baud_cnt   <= '0;
                    end else if (baud_cnt == CNT_LAST) begin
                        state    <= StStart;
                        byte_idx <= byte_idx + 1'b1;
                        uart_tx  <= 1'b0;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_port_tx.sv
// Scoreboard bench for debug_port_tx: random frames decoded by a UART monitor and checked against
// expected byte queues plus frame timing, snapshot, retrigger, back-to-back and reset cases.
module tb_debug_port_tx;

    localparam int DEBUG_BYTES = 3;
    localparam int CLKS        = 4;
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam int NB = DEBUG_BYTES + 1;
`else
    localparam int NB = DEBUG_BYTES;
`endif
    localparam int FRAME_LEN = NB * 10 * CLKS;
    localparam int BITS      = 10 * CLKS;

    logic                     clk = 1'b0;
    logic                     nreset;
    logic [8:DEBUG_BYTES*8-1] vec;
    logic                     trigger;
    logic                     uart_tx;
    logic                     busy;
    logic                     frame_done;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    debug_port_tx #(
        .DEBUG_BYTES  (DEBUG_BYTES),
        .CLKS_PER_BIT (CLKS),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk               (clk),
        .nreset            (nreset),
        .debug_port_vector (vec),
        .trigger           (trigger),
        .uart_tx           (uart_tx),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Byte k of the vector occupies bits k*8..k*8+7 with bit k*8 as its MSB.
    task automatic set_vec(input logic [7:0] b1, input logic [7:0] b2);
        vec[8:15]  = b1;
        vec[16:23] = b2;
    endtask

    task automatic push_frame(input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back(8'hA5);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
`ifdef DEBUG_TX_CHECKSUM_EN
        exp_q.push_back(b1 ^ b2);
`endif
    endtask

    // Called just after a negedge; returns at the negedge of frame cycle 1.
    task automatic start_frame(input logic [7:0] b1, input logic [7:0] b2);
        set_vec(b1, b2);
        push_frame(b1, b2);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("start_tx", uart_tx, 1'b0);
        check("start_busy", busy, 1'b1);
    endtask

    // Frame cycle 1 has been seen; walk to frame_done, optionally disturbing inputs on the way.
    task automatic wait_done(input int chg_at, input logic [7:0] n1, input logic [7:0] n2,
                             input int retrig_at);
        int c;
        bit seen;
        c = 1;
        seen = 1'b0;
        while (!seen && c < FRAME_LEN + 20) begin
            @(negedge clk);
            c++;
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                check("done_cycle", c, FRAME_LEN);
                check("busy_at_done", busy, 1'b0);
            end else begin
                check("busy_in_frame", busy, 1'b1);
            end
            if (c == chg_at) set_vec(n1, n2);
            if (c == retrig_at) trigger = 1'b1;
            else if (c == retrig_at + 1) trigger = 1'b0;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_after_done();
        @(negedge clk);
        check("done_pulse_width", frame_done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_tx", uart_tx, 1'b1);
    endtask

    // UART receiver: captures every cycle of a byte, checks bit hold times, pops expected byte.
    initial begin : monitor
        logic [BITS-1:0] s;
        logic [7:0]      d;
        bit              abort;
        forever begin
            @(posedge clk);
            #1;
            if (nreset === 1'b0 && uart_tx === 1'b0) begin
                s     = '0;
                abort = 1'b0;
                for (int c = 1; c < BITS && !abort; c++) begin
                    @(posedge clk);
                    #1;
                    if (nreset !== 1'b0) abort = 1'b1;
                    else s[c] = uart_tx;
                end
                if (!abort) begin
                    for (int i = 0; i < 8; i++) d[i] = s[(i + 1) * CLKS + CLKS / 2];
                    check("start_hold", s[CLKS-1:0], '0);
                    for (int i = 0; i < 8; i++)
                        check("data_hold", s[(i + 1) * CLKS +: CLKS], {CLKS{d[i]}});
                    check("stop_hold", s[BITS-1 -: CLKS], {CLKS{1'b1}});
                    if (exp_q.size() == 0) check("unexpected_byte", {24'd0, d}, 32'hFFFF_FFFF);
                    else check("rx_byte", d, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [7:0] a1, a2, c1, c2;
        nreset  = 1'b1;
        trigger = 1'b0;
        vec     = '0;

        repeat (3) begin
            @(negedge clk);
            check("rst_tx", uart_tx, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_done", frame_done, 1'b0);
        end
        nreset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("idle_tx", uart_tx, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_done", frame_done, 1'b0);
        end

        start_frame(8'h12, 8'h34);
        wait_done(-1, 8'h00, 8'h00, -10);
        check_after_done();

        // Live vector changes two cycles in must not leak into the frame.
        start_frame(8'h12, 8'h34);
        wait_done(2, 8'hFF, 8'hFF, -10);
        check_after_done();

        // Retrigger mid-frame is dropped: no second frame follows.
        start_frame(8'($urandom), 8'($urandom));
        wait_done(-1, 8'h00, 8'h00, 50);
        repeat (60) begin
            @(negedge clk);
            check("no_retrigger_busy", busy, 1'b0);
            check("no_retrigger_tx", uart_tx, 1'b1);
        end

        for (int i = 0; i < 5; i++) begin
            start_frame(8'($urandom), 8'($urandom));
            wait_done(-1, 8'h00, 8'h00, -10);
            check_after_done();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Held trigger: second frame uses a fresh snapshot and starts right after frame_done.
        a1 = 8'($urandom);
        a2 = 8'($urandom);
        c1 = ~a1;
        c2 = ~a2;
        set_vec(a1, a2);
        push_frame(a1, a2);
        push_frame(c1, c2);
        trigger = 1'b1;
        @(negedge clk);
        check("start_tx", uart_tx, 1'b0);
        wait_done(5, c1, c2, -10);
        @(negedge clk);
        check("b2b_start_tx", uart_tx, 1'b0);
        check("b2b_busy", busy, 1'b1);
        check("b2b_done_low", frame_done, 1'b0);
        trigger = 1'b0;
        wait_done(-1, 8'h00, 8'h00, -10);
        check_after_done();

        // Reset at frame cycle 30 abandons the frame.
        start_frame(8'($urandom), 8'($urandom));
        repeat (29) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("midrst_tx", uart_tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", frame_done, 1'b0);
        nreset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        start_frame(8'($urandom), 8'($urandom));
        wait_done(-1, 8'h00, 8'h00, -10);
        check_after_done();

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
